bus_xfer_ctrl: RTL and testbench



---
 rtl/bus_ctrl_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/bus_xfer_ctrl.sv | 76 +++++++
 tb/tb_bus_xfer_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared constants, FSM state type and select decoder for the bus transfer controller
package bus_ctrl_pkg;
  localparam int SEL_W = 4;
  localparam int NUM_REGS = 16;
  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;
  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_REGS'(1) << sel;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after the pointer
//   i_req   : per-requester request vector
//   i_ptr   : requester index with highest priority this round
//   o_idx   : winning requester index (valid only when o_valid)
//   o_valid : any request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [PW-1:0]      o_idx,
  output logic               o_valid
);
  logic [PW-1:0] w_cand;
  // Scan from the farthest candidate back to the pointer so the nearest set bit wins last.
  always_comb begin
    o_idx = '0;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = PW'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: round-robin sequencer of register-to-register transfers over the shared bus
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_req                : per-requester level request, held until o_done
//   i_src_sel/i_dst_sel  : per-requester source/destination, requester i at [i*SEL_W +: SEL_W]
//   o_grant              : one-hot winner during DRIVE and WRITE
//   o_done               : one-hot one-cycle pulse in WRITE
//   o_err                : pulse with o_done for a rejected write to register 0
//   o_sel                : bus mux select (latched source, holds while idle)
//   o_load_en            : one-hot destination load enable in WRITE
//   o_busy               : high while not IDLE
// Build option: define R0_PROTECT_EN to block writes to register 0 and flag them on o_err.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*SEL_W-1:0] i_src_sel,
  input  logic [NUM_REQ*SEL_W-1:0] i_dst_sel,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic [SEL_W-1:0]         o_sel,
  output logic [NUM_REGS-1:0]      o_load_en,
  output logic                     o_busy
);
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_win, w_win;
  logic w_valid, w_prot;
  logic [SEL_W-1:0] r_src, r_dst;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_idx  (w_win),
    .o_valid(w_valid)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // The command is captured only in IDLE, so requester changes mid-transfer are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_win <= '0;
      r_src <= '0;
      r_dst <= '0;
    end else begin
      if (r_state == IDLE && w_valid) begin
        r_win <= w_win;
        r_src <= i_src_sel[w_win*SEL_W +: SEL_W];
        r_dst <= i_dst_sel[w_win*SEL_W +: SEL_W];
      end
      if (r_state == WRITE) r_ptr <= (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
    end
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (w_valid ? DRIVE : IDLE) : (r_state == DRIVE) ? WRITE : IDLE;
  end
`ifdef R0_PROTECT_EN
  assign w_prot = (r_dst == '0);
`else
  assign w_prot = 1'b0;
`endif
  always_comb begin
    o_busy = (r_state != IDLE);
    o_grant = o_busy ? NUM_REQ'(1) << r_win : '0;
    o_done = (r_state == WRITE) ? NUM_REQ'(1) << r_win : '0;
    o_load_en = (r_state == WRITE && !w_prot) ? sel_onehot(r_dst) : '0;
    o_err = (r_state == WRITE) && w_prot;
    o_sel = r_src;
  end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: directed and randomized checks of bus_xfer_ctrl against a transfer-level model
module tb_bus_xfer_ctrl;
  localparam int N = 4;
  localparam int SW = 4;
  localparam int NR = 16;
`ifdef R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N*SW-1:0] src, dst;
  logic [N-1:0] o_grant, o_done;
  logic o_err, o_busy;
  logic [SW-1:0] o_sel;
  logic [NR-1:0] o_load_en;
  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  always #5 clk = ~clk;
  bus_xfer_ctrl #(.NUM_REQ(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_src_sel(src), .i_dst_sel(dst),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_sel(o_sel),
    .o_load_en(o_load_en), .o_busy(o_busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Transfer-level model: m_age counts cycles since the command was accepted (0 = none in flight).
  int m_age = 0, m_win = 0, m_ptr = 0;
  logic [SW-1:0] m_src = '0, m_dst = '0;
  int waits[N];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_ptr = 0; m_win = 0; m_src = '0; m_dst = '0;
      foreach (waits[i]) waits[i] = 0;
    end else if (m_age == 1) m_age = 2;
    else if (m_age == 2) begin
      m_ptr = (m_win + 1) % N;
      m_age = 0;
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_win = (m_ptr + k) % N;
          break;
        end
      end
      m_src = src[m_win*SW +: SW];
      m_dst = dst[m_win*SW +: SW];
      m_age = 1;
      for (int i = 0; i < N; i++) begin
        if (i == m_win) begin
          chk("fair_wait", 32'(waits[i] <= N - 1), 1);
          waits[i] = 0;
        end else waits[i] = req[i] ? waits[i] + 1 : 0;
      end
    end
  end
  always @(negedge clk) begin
    if (cmp_en) begin
      logic wr, bad;
      wr = (m_age == 2);
      bad = PROT && (m_dst == '0);
      chk("busy", 32'(o_busy), 32'(m_age != 0));
      chk("grant", 32'(o_grant), (m_age != 0) ? 32'(1) << m_win : 0);
      chk("done", 32'(o_done), wr ? 32'(1) << m_win : 0);
      chk("load_en", 32'(o_load_en), (wr && !bad) ? 32'(1) << m_dst : 0);
      chk("err", 32'(o_err), 32'(wr && bad));
      chk("sel", 32'(o_sel), 32'(m_src));
    end
  end
  task automatic wait_done(input string nm);
    int c = 0;
    @(negedge clk);
    while (o_done == '0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_timeout"}, 32'(o_done != '0), 1);
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '0; src = '0; dst = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_sel", 32'(o_sel), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_load", 32'(o_load_en), 0);
    // single transfer 3 -> 7
    src[0 +: SW] = 4'd3; dst[0 +: SW] = 4'd7; req = 4'b0001;
    @(negedge clk);
    chk("t1_drive_sel", 32'(o_sel), 3);
    chk("t1_drive_grant", 32'(o_grant), 1);
    chk("t1_drive_load", 32'(o_load_en), 0);
    @(negedge clk);
    chk("t1_write_sel", 32'(o_sel), 3);
    chk("t1_write_load", 32'(o_load_en), 32'h0080);
    chk("t1_write_done", 32'(o_done), 1);
    req = '0;
    @(negedge clk);
    chk("t1_idle_busy", 32'(o_busy), 0);
    // round robin with all requests held
    pulse_rst();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      src[i*SW +: SW] = SW'(i + 1);
      dst[i*SW +: SW] = SW'(i + 8);
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done("t2");
      chk("t2_rr_order", 32'(o_done), 32'(1) << order[t]);
    end
    req = '0;
    // move the pointer to 2, then contend 0 and 1
    @(negedge clk);
    src[1*SW +: SW] = 4'd2; dst[1*SW +: SW] = 4'd3; req = 4'b0010;
    wait_done("t3a");
    chk("t3_first", 32'(o_done), 32'b0010);
    req = 4'b0011;
    wait_done("t3b");
    chk("t3_wrap", 32'(o_done), 32'b0001);
    req = 4'b0010;
    wait_done("t3c");
    chk("t3_next", 32'(o_done), 32'b0010);
    req = '0;
    // reset during DRIVE
    @(negedge clk);
    src[1*SW +: SW] = 4'd1; dst[1*SW +: SW] = 4'd9; req = 4'b0010;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_busy", 32'(o_busy), 0);
    chk("t4_async_grant", 32'(o_grant), 0);
    chk("t4_async_load", 32'(o_load_en), 0);
    chk("t4_async_sel", 32'(o_sel), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_done("t4");
    chk("t4_done", 32'(o_done), 32'b0010);
    chk("t4_load", 32'(o_load_en), 32'h0200);
    req = '0;
    // inputs changed after latch
    @(negedge clk);
    src[1*SW +: SW] = 4'd5; dst[1*SW +: SW] = 4'd6; req = 4'b0010;
    @(posedge clk);
    #1 src[1*SW +: SW] = 4'd9; dst[1*SW +: SW] = 4'd2;
    @(negedge clk);
    chk("t5_drive_sel", 32'(o_sel), 5);
    @(negedge clk);
    chk("t5_write_sel", 32'(o_sel), 5);
    chk("t5_write_load", 32'(o_load_en), 32'h0040);
    req = '0;
    // destination register 0
    @(negedge clk);
    src[2*SW +: SW] = 4'd4; dst[2*SW +: SW] = 4'd0; req = 4'b0100;
    wait_done("t6");
    chk("t6_done", 32'(o_done), 32'b0100);
    chk("t6_load", 32'(o_load_en), PROT ? 0 : 1);
    chk("t6_err", 32'(o_err), 32'(PROT));
    req = '0;
    // randomized requesters obeying the hold-until-done contract
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (m_age == 2 && m_win == i) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          else begin
            src[i*SW +: SW] = SW'($urandom_range(15));
            dst[i*SW +: SW] = SW'($urandom_range(15));
          end
        end else if (m_age == 1 && m_win == i) begin
          if ($urandom_range(3) == 0) src[i*SW +: SW] = SW'($urandom_range(15));
        end else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          src[i*SW +: SW] = SW'($urandom_range(15));
          dst[i*SW +: SW] = SW'($urandom_range(15));
        end
      end
      if ($urandom_range(150) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
